// File: rtl/iic_xfer_arbiter.sv
// Round-robin sequencer sharing one byte-level I2C master core between two
// write requesters: TXR load, CTR start, SR ack poll, next/stop, SR idle poll.
//
// state      | meaning
// IDLE       | core free, arbitrating between requesters
// LOAD       | waiting for / writing owner byte into TXR
// START      | CTR write with start, write mode
// POLL_ACK   | polling SR for waiting-ack status
// NEXT       | next-byte pulse to core
// STOP       | CTR write clearing start
// POLL_IDLE  | polling SR until core reports idle
// ABORT      | timeout: stop written, error reported
module iic_xfer_arbiter #(
    parameter int          TIMEOUT_CYC  = 4096,
    parameter int          TW           = 13,
    parameter logic [7:0]  CTR_WR_START = 8'h03,
    parameter logic [7:0]  CTR_STOP     = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        busy,
    output logic [1:0]  core_adr,
    output logic [7:0]  core_wdata,
    output logic        core_cs,
    output logic        core_next,
    input  logic [7:0]  core_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_POLL_ACK,
        S_NEXT,
        S_STOP,
        S_POLL_IDLE,
        S_ABORT
    } state_t;

    localparam logic [1:0]    ADR_TXR     = 2'b00;
    localparam logic [1:0]    ADR_SR      = 2'b10;
    localparam logic [1:0]    ADR_CTR     = 2'b11;
    localparam logic [7:0]    SR_WAIT_ACK = 8'h08;
    localparam logic [7:0]    SR_IDLE     = 8'h00;
    localparam logic [TW-1:0] TMO_TC      = TW'(TIMEOUT_CYC);

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        ptr, ptr_nxt;
    logic        last_q, last_nxt;
    logic [1:0]  grant_nxt;
    logic [1:0]  done_nxt;
    logic [1:0]  err_nxt;
    logic [TW-1:0] tmo_cnt;

    logic        tmo_hit;
    logic        first_poll;
    logic        sel_valid;
    logic [7:0]  sel_data;
    logic        sel_last;
    logic [1:0]  owner_oh;
    logic        tmo_run;

    assign tmo_hit    = (tmo_cnt == TMO_TC);
    assign first_poll = (tmo_cnt == '0);
    assign sel_valid  = owner ? req_valid[1] : req_valid[0];
    assign sel_data   = owner ? req_data[15:8] : req_data[7:0];
    assign sel_last   = owner ? req_last[1] : req_last[0];
    assign owner_oh   = owner ? 2'b10 : 2'b01;
    assign busy       = |grant;
    assign tmo_run    = (state == S_LOAD) || (state == S_POLL_ACK) || (state == S_POLL_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            owner   <= 1'b0;
            ptr     <= 1'b0;
            last_q  <= 1'b0;
            grant   <= 2'b00;
            done    <= 2'b00;
            err     <= 2'b00;
            tmo_cnt <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            ptr    <= ptr_nxt;
            last_q <= last_nxt;
            grant  <= grant_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
            // Counter restarts on every state change, so each wait phase gets a full budget.
            if (state_nxt != state) begin
                tmo_cnt <= '0;
            end else if (tmo_run) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        ptr_nxt    = ptr;
        last_nxt   = last_q;
        grant_nxt  = grant;
        done_nxt   = 2'b00;
        err_nxt    = 2'b00;
        req_ready  = 2'b00;
        core_adr   = ADR_SR;
        core_wdata = 8'h00;
        core_cs    = 1'b0;
        core_next  = 1'b0;

        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    owner_nxt = req_valid[ptr] ? ptr : ~ptr;
                    grant_nxt = owner_nxt ? 2'b10 : 2'b01;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (sel_valid) begin
                    req_ready  = owner_oh;
                    core_adr   = ADR_TXR;
                    core_wdata = sel_data;
                    core_cs    = 1'b1;
                    last_nxt   = sel_last;
                    state_nxt  = S_START;
                end else if (tmo_hit) begin
                    state_nxt = S_ABORT;
                    err_nxt   = owner_oh;
                    grant_nxt = 2'b00;
                    ptr_nxt   = ~owner;
                end
            end
            S_START: begin
                core_adr   = ADR_CTR;
                core_wdata = CTR_WR_START;
                core_cs    = 1'b1;
                state_nxt  = S_POLL_ACK;
            end
            S_POLL_ACK: begin
                // First poll cycle carries stale SR from before the address settled.
                if (!first_poll && core_rdata == SR_WAIT_ACK) begin
                    state_nxt = last_q ? S_STOP : S_NEXT;
                end else if (tmo_hit) begin
                    state_nxt = S_ABORT;
                    err_nxt   = owner_oh;
                    grant_nxt = 2'b00;
                    ptr_nxt   = ~owner;
                end
            end
            S_NEXT: begin
                core_next = 1'b1;
                state_nxt = S_LOAD;
            end
            S_STOP: begin
                core_adr   = ADR_CTR;
                core_wdata = CTR_STOP;
                core_cs    = 1'b1;
                state_nxt  = S_POLL_IDLE;
            end
            S_POLL_IDLE: begin
                if (!first_poll && core_rdata == SR_IDLE) begin
                    state_nxt = S_IDLE;
                    done_nxt  = owner_oh;
                    grant_nxt = 2'b00;
                    ptr_nxt   = ~owner;
                end else if (tmo_hit) begin
                    state_nxt = S_ABORT;
                    err_nxt   = owner_oh;
                    grant_nxt = 2'b00;
                    ptr_nxt   = ~owner;
                end
            end
            S_ABORT: begin
                core_adr   = ADR_CTR;
                core_wdata = CTR_STOP;
                core_cs    = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iic_xfer_arbiter.sv
// Scoreboard bench for iic_xfer_arbiter with a scripted SR model of the I2C core.
module tb_iic_xfer_arbiter;

    localparam int TIMEOUT_CYC = 4096;

    localparam logic [3:0] K_TXR  = 4'd1;
    localparam logic [3:0] K_CTR  = 4'd2;
    localparam logic [3:0] K_NEXT = 4'd3;
    localparam logic [3:0] K_DONE = 4'd4;
    localparam logic [3:0] K_ERR  = 4'd5;
    localparam logic [3:0] K_BAD  = 4'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [7:0]  d0 = 8'h00, d1 = 8'h00;
    logic [1:0]  req_valid, req_last, req_ready, grant, done, err, core_adr;
    logic [15:0] req_data;
    logic        busy, core_cs, core_next;
    logic [7:0]  core_wdata;
    logic [7:0]  core_rdata = 8'h00;

    assign req_valid = {v1, v0};
    assign req_data  = {d1, d0};
    assign req_last  = {l1, l0};

    always #5 clk = ~clk;

    iic_xfer_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .core_adr   (core_adr),
        .core_wdata (core_wdata),
        .core_cs    (core_cs),
        .core_next  (core_next),
        .core_rdata (core_rdata)
    );

    // Core SR model: a start write arms the ack script, a stop write arms the idle script.
    logic [7:0] sr_q[$];
    logic       sr_hold = 1'b0;

    always @(posedge clk) begin
        if (core_cs && core_adr == 2'b11 && core_wdata == 8'h03) begin
            if (sr_hold) sr_q = '{8'h0A};
            else         sr_q = '{8'h09, 8'h0A, 8'h08};
        end else if (core_cs && core_adr == 2'b11 && core_wdata == 8'h00) begin
            sr_q = '{8'h0C, 8'h00};
        end
        if (sr_q.size() > 0) begin
            core_rdata <= sr_q[0];
            if (sr_q.size() > 1) void'(sr_q.pop_front());
        end
    end

    logic [11:0] exp_ev[$];
    logic [1:0]  exp_grant[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          start_cyc = 0, err_cyc = 0, done_cyc = 0, rr_gap = 0;
    logic [1:0]  prev_grant = 2'b00;
    logic [1:0]  prev_adr = 2'b10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic observe_ev(input logic [11:0] got);
        if (exp_ev.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event got=%0h exp=none", got);
        end else begin
            check("event", got, exp_ev.pop_front());
        end
    endtask

    task automatic observe_grant(input logic [1:0] got);
        if (exp_grant.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_grant got=%0h exp=none", got);
        end else begin
            check("grant_order", got, exp_grant.pop_front());
        end
    endtask

    task automatic expect_txn(input int r, input int n, input logic [23:0] b);
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        exp_grant.push_back(oh);
        for (int k = 0; k < n; k++) begin
            exp_ev.push_back({K_TXR, b[8*k +: 8]});
            exp_ev.push_back({K_CTR, 8'h03});
            if (k < n - 1) exp_ev.push_back({K_NEXT, 8'h00});
        end
        exp_ev.push_back({K_CTR, 8'h00});
        exp_ev.push_back({K_DONE, 6'd0, oh});
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
        if (r == 0) begin v0 = v; d0 = d; l0 = l; end
        else        begin v1 = v; d1 = d; l1 = l; end
    endtask

    task automatic wait_ready(input int r);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!req_ready[r] && waited < 200);
        check("ready_wait", req_ready[r], 1'b1);
    endtask

    task automatic send_txn(input int r, input int n, input logic [23:0] b);
        for (int k = 0; k < n; k++) begin
            set_req(r, 1'b1, b[8*k +: 8], k == n - 1);
            wait_ready(r);
            @(posedge clk);
            #1;
        end
        set_req(r, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input int budget);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            #2;
            waited++;
        end while ((exp_ev.size() != 0 || busy) && waited < budget);
        check("drain_events", exp_ev.size(), 0);
        check("drain_grants", exp_grant.size(), 0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (!rst) begin
                        if (core_cs) begin
                            observe_ev({(core_adr == 2'b00) ? K_TXR :
                                        (core_adr == 2'b11) ? K_CTR : K_BAD, core_wdata});
                            if (core_adr == 2'b11 && core_wdata == 8'h03) start_cyc = cyc;
                        end
                        if (core_next) observe_ev({K_NEXT, 8'h00});
                        if (done != 2'b00) begin
                            observe_ev({K_DONE, 6'd0, done});
                            check("done_released", {busy, grant}, 3'b000);
                            done_cyc = cyc;
                        end
                        if (err != 2'b00) begin
                            observe_ev({K_ERR, 6'd0, err});
                            check("err_released", {busy, grant}, 3'b000);
                            err_cyc = cyc;
                        end
                        if (grant != 2'b00 && prev_grant == 2'b00) begin
                            observe_grant(grant);
                            rr_gap = cyc - done_cyc;
                        end
                        check("adr_idle", core_cs || core_adr == 2'b10, 1'b1);
                        check("adr_single", core_adr == 2'b10 || core_adr != prev_adr, 1'b1);
                        check("grant_onehot", $countones(grant) <= 1, 1'b1);
                        check("ready_owner", req_ready & ~grant, 2'b00);
                        check("busy", busy, grant != 2'b00);
                    end
                    prev_grant = grant;
                    prev_adr   = core_adr;
                end
            end
            begin : stimulus
                int waited;
                #1 rst = 1'b1;
                repeat (3) @(negedge clk);
                check("rst_grant", grant, 2'b00);
                check("rst_ready", req_ready, 2'b00);
                check("rst_done", done, 2'b00);
                check("rst_err", err, 2'b00);
                check("rst_busy", busy, 1'b0);
                check("rst_adr", core_adr, 2'b10);
                check("rst_wdata", core_wdata, 8'h00);
                check("rst_cs", core_cs, 1'b0);
                check("rst_next", core_next, 1'b0);
                rst = 1'b0;
                repeat (2) @(negedge clk);

                // single byte, no next pulse
                expect_txn(0, 1, 24'h0000A5);
                send_txn(0, 1, 24'h0000A5);
                drain(200);

                // three bytes from requester 1
                expect_txn(1, 3, 24'h332211);
                send_txn(1, 3, 24'h332211);
                drain(300);

                // simultaneous requests after reset
                pulse_rst();
                expect_txn(0, 1, 24'h0000AA);
                expect_txn(1, 1, 24'h0000BB);
                fork
                    send_txn(0, 1, 24'h0000AA);
                    send_txn(1, 1, 24'h0000BB);
                join
                drain(300);
                check("rr_gap_1", rr_gap, 1);
                expect_txn(0, 1, 24'h0000CC);
                expect_txn(1, 1, 24'h0000DD);
                fork
                    send_txn(0, 1, 24'h0000CC);
                    send_txn(1, 1, 24'h0000DD);
                join
                drain(300);
                check("rr_gap_2", rr_gap, 1);

                // SR stuck at 0A: ack-poll timeout
                sr_hold = 1'b1;
                exp_grant.push_back(2'b01);
                exp_ev.push_back({K_TXR, 8'h5A});
                exp_ev.push_back({K_CTR, 8'h03});
                exp_ev.push_back({K_CTR, 8'h00});
                exp_ev.push_back({K_ERR, 8'h01});
                send_txn(0, 1, 24'h00005A);
                drain(TIMEOUT_CYC + 200);
                check("abort_timing", err_cyc - start_cyc, TIMEOUT_CYC + 2);
                sr_hold = 1'b0;
                repeat (2) @(negedge clk);

                // reset in the middle of a two-byte transfer
                sr_hold = 1'b1;
                exp_grant.push_back(2'b01);
                exp_ev.push_back({K_TXR, 8'h77});
                exp_ev.push_back({K_CTR, 8'h03});
                set_req(0, 1'b1, 8'h77, 1'b0);
                wait_ready(0);
                @(posedge clk);
                #1;
                set_req(0, 1'b0, 8'h00, 1'b0);
                repeat (3) @(negedge clk);
                #2;
                check("mid_events", exp_ev.size(), 0);
                check("mid_grant", grant, 2'b01);
                rst = 1'b1;
                #1;
                check("mid_rst_grant", grant, 2'b00);
                check("mid_rst_adr", core_adr, 2'b10);
                check("mid_rst_cs", core_cs, 1'b0);
                check("mid_rst_busy", busy, 1'b0);
                repeat (2) @(negedge clk);
                sr_hold = 1'b0;
                rst = 1'b0;
                repeat (2) @(negedge clk);
                expect_txn(0, 1, 24'h000099);
                send_txn(0, 1, 24'h000099);
                drain(200);

                waited = 0;
                repeat (10) @(negedge clk);
                check("final_events", exp_ev.size(), 0);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
